// File: rtl/filt_lt_avg_mc.sv
// filt_lt_avg_mc
// Multi-channel long-term magnitude averaging filter for the ADPCM
// speed-control path. Each channel keeps an averaged value D that moves
// toward (FI << FSH) by 1/2^SH of the difference on every accepted sample.
// Two pipeline stages: S1 captures channel, FI and D; S2 registers the
// result and writes it back. S1 takes a result straight from S2 when both
// stages work on the same channel in the same cycle, so consecutive samples
// on one channel build on each other. A clear request first waits for the
// pipeline to empty, then resets one channel per cycle.
// Optional build macro: FILT_HOLD_EN adds an in_hold input. A held sample
// outputs the current D and leaves the stored state unchanged.

module filt_lt_avg_mc #(
    parameter int             W    = 14,
    parameter int             FW   = 3,
    parameter int             FSH  = 11,
    parameter int             SH   = 7,
    parameter int             NCH  = 8,
    parameter int             CW   = 3,
    parameter logic [W-1:0]   INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW-1:0]     in_ch,
    input  logic [FW-1:0]     in_fi,
`ifdef FILT_HOLD_EN
    input  logic              in_hold,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     out_ch,
    output logic [W-1:0]      dout,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_SWEEP = 2'd2;

    // Correction that turns a logical right shift of a negative difference
    // into a sign-extended one, truncated to W bits.
    localparam int           SX_ADD_I = (2 ** W) - (2 ** (W + 1 - SH));
    localparam logic [W-1:0] SX_ADD   = W'(SX_ADD_I);

    logic [W-1:0]  r_state [NCH];

    logic          r_s1Valid;
    logic [CW-1:0] r_s1Ch;
    logic [FW-1:0] r_s1Fi;
    logic [W-1:0]  r_s1D;
    logic          r_s1Oor;
    logic          r_s1Hold;

    logic          r_outValid;
    logic [CW-1:0] r_outCh;
    logic [W-1:0]  r_dout;

    logic [1:0]    r_clrState;
    logic [CW-1:0] r_sweepIdx;

    logic          w_clrBusy;
    logic          w_inReady;
    logic          w_accept;
    logic          w_s2Advance;
    logic          w_s1Advance;
    logic          w_inOor;
    logic          w_inHold;
    logic [W:0]    w_fiShift;
    logic [W:0]    w_dif;
    logic [W-1:0]  w_difSx;
    logic [W-1:0]  w_dNew;
    logic [W-1:0]  w_result;
    logic          w_write;
    logic          w_fwd;
    logic [W-1:0]  w_readD;

`ifdef FILT_HOLD_EN
    assign w_inHold = in_hold;
`else
    assign w_inHold = 1'b0;
`endif

    // Channel indices at or above NCH can only exist when NCH is not a power of two.
    generate
        if (NCH < (2 ** CW)) begin : g_oorCheck
            assign w_inOor = (int'(in_ch) >= NCH);
        end else begin : g_noOor
            assign w_inOor = 1'b0;
        end
    endgenerate

    assign w_clrBusy   = (r_clrState != ST_IDLE);
    assign w_s2Advance = !r_outValid || out_ready;
    assign w_s1Advance = r_s1Valid && w_s2Advance;
    assign w_inReady   = !w_clrBusy && (!r_s1Valid || w_s2Advance);
    assign w_accept    = in_valid && w_inReady;

    // D' = D + sign-extended ((FI << FSH) - D) >> SH, all modulo 2^W.
    assign w_fiShift = (W + 1)'(r_s1Fi) << FSH;
    assign w_dif     = w_fiShift - {1'b0, r_s1D};
    assign w_difSx   = W'(w_dif >> SH) + (w_dif[W] ? SX_ADD : '0);
    assign w_dNew    = w_difSx + r_s1D;
    assign w_result  = r_s1Hold ? r_s1D : w_dNew;

    // Only in-range, unheld samples write back, so only those are forwarded.
    assign w_write = w_s1Advance && !r_s1Oor && !r_s1Hold;
    assign w_fwd   = w_write && (r_s1Ch == in_ch);
    assign w_readD = w_inOor ? INIT : (w_fwd ? w_dNew : r_state[in_ch]);

    // S1: capture channel, FI and the current (possibly forwarded) D on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1Ch    <= '0;
            r_s1Fi    <= '0;
            r_s1D     <= '0;
            r_s1Oor   <= 1'b0;
            r_s1Hold  <= 1'b0;
        end else if (w_accept) begin
            r_s1Valid <= 1'b1;
            r_s1Ch    <= in_ch;
            r_s1Fi    <= in_fi;
            r_s1D     <= w_readD;
            r_s1Oor   <= w_inOor;
            r_s1Hold  <= w_inHold;
        end else if (w_s2Advance) begin
            r_s1Valid <= 1'b0;
        end
    end

    // S2: register the result when S1 advances; drop it once downstream takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_outCh    <= '0;
            r_dout     <= '0;
        end else if (w_s1Advance) begin
            r_outValid <= 1'b1;
            r_outCh    <= r_s1Ch;
            r_dout     <= w_result;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    // Per-channel state: the sweep clears one entry per cycle, otherwise S2 writes back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_state[i] <= INIT;
            end
        end else if (r_clrState == ST_SWEEP) begin
            r_state[r_sweepIdx] <= INIT;
        end else if (w_write) begin
            r_state[r_s1Ch] <= w_dNew;
        end
    end

    // Clear sequencer: wait for an empty pipeline, then sweep channels 0..NCH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clrState <= ST_IDLE;
            r_sweepIdx <= '0;
        end else begin
            case (r_clrState)
                ST_IDLE: begin
                    if (clr_req) begin
                        r_clrState <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!r_s1Valid && !r_outValid) begin
                        r_clrState <= ST_SWEEP;
                        r_sweepIdx <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (r_sweepIdx == CW'(NCH - 1)) begin
                        r_clrState <= ST_IDLE;
                        r_sweepIdx <= '0;
                    end else begin
                        r_sweepIdx <= r_sweepIdx + 1'b1;
                    end
                end
                default: begin
                    r_clrState <= ST_IDLE;
                    r_sweepIdx <= '0;
                end
            endcase
        end
    end

    assign in_ready  = w_inReady;
    assign out_valid = r_outValid;
    assign out_ch    = r_outCh;
    assign dout      = r_dout;
    assign clr_busy  = w_clrBusy;

endmodule

// File: tb/tb_filt_lt_avg_mc.sv
// tb_filt_lt_avg_mc
// Directed bench for filt_lt_avg_mc with default parameters. Expected
// results are worked out by hand from the averaging formula. The in_hold
// scenario is built only when FILT_HOLD_EN is defined.

module tb_filt_lt_avg_mc;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_ch;
    logic [2:0]  in_fi;
`ifdef FILT_HOLD_EN
    logic        in_hold;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_ch;
    logic [13:0] dout;
    logic        clr_req;
    logic        clr_busy;

    int checks;
    int errors;

    filt_lt_avg_mc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_fi     (in_fi),
`ifdef FILT_HOLD_EN
        .in_hold   (in_hold),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .dout      (dout),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the run wedges somewhere unexpected
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired, simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    // Presents one sample from a falling edge and returns on the falling edge after acceptance
    task automatic applyStimulus(input logic [2:0] ch, input logic [2:0] fi, input logic hold);
        int waitCnt;
        in_valid = 1'b1;
        in_ch    = ch;
        in_fi    = fi;
`ifdef FILT_HOLD_EN
        in_hold  = hold;
`else
        if (hold) $display("[TB] hold requested but FILT_HOLD_EN not built");
`endif
        waitCnt = 0;
        while (!in_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL accept_timeout ch=%0d in_ready=%b required 1", ch, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
`ifdef FILT_HOLD_EN
        in_hold  = 1'b0;
`endif
    endtask

    // Waits (bounded) for out_valid with out_ready high and returns the result
    task automatic getResult(output logic [13:0] d, output logic [2:0] ch);
        int waitCnt;
        waitCnt = 0;
        while (!out_valid && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL result_timeout out_valid=%b required 1", out_valid);
        end
        d  = dout;
        ch = out_ch;
        @(negedge clk);
    endtask

    // Reset values, held and after release
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_ch     = '0;
        in_fi     = '0;
`ifdef FILT_HOLD_EN
        in_hold   = 1'b0;
`endif
        out_ready = 1'b1;
        clr_req   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_ch, dout, clr_busy} !== 19'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got valid=%b ch=%0d dout=%0d busy=%b required all 0",
                     out_valid, out_ch, dout, clr_busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready got %b required 1", in_ready);
        end
    endtask

    // Single samples: zero input, positive step, negative difference, top channel
    task automatic test_basic();
        logic [13:0] d;
        logic [2:0]  oc;
        logic [2:0]  chs [4];
        logic [2:0]  fis [4];
        int          exps [4];
        chs  = '{3'd0, 3'd0, 3'd0, 3'd7};
        fis  = '{3'd0, 3'd7, 3'd0, 3'd7};
        exps = '{0, 112, 111, 112};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(chs[i], fis[i], 1'b0);
            getResult(d, oc);
            checks++;
            if (d !== 14'(exps[i]) || oc !== chs[i]) begin
                errors++;
                $display("[TB] FAIL basic_%0d got dout=%0d ch=%0d required dout=%0d ch=%0d",
                         i, d, oc, exps[i], chs[i]);
            end
        end
    endtask

    // Spaced samples on ch1 with mixed FI, ending in a negative difference
    task automatic test_chain();
        logic [13:0] d;
        logic [2:0]  oc;
        logic [2:0]  fis [7];
        int          exps [7];
        fis  = '{3'd7, 3'd7, 3'd7, 3'd3, 3'd7, 3'd1, 3'd0};
        exps = '{112, 223, 333, 378, 487, 499, 495};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(3'd1, fis[i], 1'b0);
            getResult(d, oc);
            checks++;
            if (d !== 14'(exps[i]) || oc !== 3'd1) begin
                errors++;
                $display("[TB] FAIL chain_%0d got dout=%0d ch=%0d required dout=%0d ch=1",
                         i, d, oc, exps[i]);
            end
        end
    endtask

    // Three consecutive samples on ch2 must chain through forwarding
    task automatic test_back_to_back();
        int exps [3];
        exps = '{112, 223, 333};
        in_valid = 1'b1;
        in_ch    = 3'd2;
        in_fi    = 3'd7;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_ready got %b required 1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 1) in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || dout !== 14'(exps[i]) || out_ch !== 3'd2) begin
                errors++;
                $display("[TB] FAIL b2b_%0d got valid=%b dout=%0d ch=%0d required valid=1 dout=%0d ch=2",
                         i, out_valid, dout, out_ch, exps[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_drain got valid=%b required 0", out_valid);
        end
    endtask

    // Two ch4 samples stalled behind out_ready=0, then released
    task automatic test_backpressure();
        logic [13:0] d;
        logic [2:0]  oc;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ch     = 3'd4;
        in_fi     = 3'd7;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || dout !== 14'd112 || out_ch !== 3'd4) begin
                errors++;
                $display("[TB] FAIL stall_%0d got ready=%b valid=%b dout=%0d ch=%0d required ready=0 valid=1 dout=112 ch=4",
                         k, in_ready, out_valid, dout, out_ch);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || dout !== 14'd223 || out_ch !== 3'd4) begin
            errors++;
            $display("[TB] FAIL stall_release got valid=%b dout=%0d ch=%0d required valid=1 dout=223 ch=4",
                     out_valid, dout, out_ch);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_empty got valid=%b required 0", out_valid);
        end
        applyStimulus(3'd4, 3'd0, 1'b0);
        getResult(d, oc);
        checks++;
        if (d !== 14'd221 || oc !== 3'd4) begin
            errors++;
            $display("[TB] FAIL stall_state got dout=%0d ch=%0d required dout=221 ch=4", d, oc);
        end
    endtask

    // Clear with one sample in flight and a repeated request during the sweep
    task automatic test_clear();
        logic [13:0] d;
        logic [2:0]  oc;
        int          busyCnt;
        int          badReady;
        logic [13:0] captured;
        logic        seen;
        busyCnt  = 0;
        badReady = 0;
        captured = '0;
        seen     = 1'b0;
        in_valid = 1'b1;
        in_ch    = 3'd3;
        in_fi    = 3'd7;
        clr_req  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        clr_req  = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (!clr_busy && busyCnt > 0) break;
            if (clr_busy) begin
                busyCnt++;
                if (in_ready) badReady++;
            end
            if (out_valid) begin
                captured = dout;
                seen     = 1'b1;
            end
            clr_req = (i == 5);
            @(negedge clk);
        end
        clr_req = 1'b0;
        checks++;
        if (busyCnt !== 11) begin
            errors++;
            $display("[TB] FAIL clear_busy_cycles got %0d required 11", busyCnt);
        end
        checks++;
        if (badReady !== 0) begin
            errors++;
            $display("[TB] FAIL clear_in_ready got %0d ready cycles required 0", badReady);
        end
        checks++;
        if (!seen || captured !== 14'd112) begin
            errors++;
            $display("[TB] FAIL clear_inflight got seen=%b dout=%0d required seen=1 dout=112", seen, captured);
        end
        for (int c = 0; c < 8; c++) begin
            applyStimulus(3'(c), 3'd0, 1'b0);
            getResult(d, oc);
            checks++;
            if (d !== 14'd0 || oc !== 3'(c)) begin
                errors++;
                $display("[TB] FAIL clear_ch%0d got dout=%0d ch=%0d required dout=0 ch=%0d", c, d, oc, c);
            end
        end
    endtask

    // Reset asserted mid-sweep and mid-pipeline
    task automatic test_reset_midway();
        logic [13:0] d;
        logic [2:0]  oc;
        applyStimulus(3'd6, 3'd7, 1'b0);
        getResult(d, oc);
        checks++;
        if (d !== 14'd112) begin
            errors++;
            $display("[TB] FAIL midrst_pre got dout=%0d required 112", d);
        end
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (clr_busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_sweep got busy=%b valid=%b required 0 0", clr_busy, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(3'd6, 3'd7, 1'b0);
        getResult(d, oc);
        checks++;
        if (d !== 14'd112 || oc !== 3'd6) begin
            errors++;
            $display("[TB] FAIL midrst_state got dout=%0d ch=%0d required dout=112 ch=6", d, oc);
        end
        in_valid = 1'b1;
        in_ch    = 3'd5;
        in_fi    = 3'd7;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dout !== 14'd0) begin
            errors++;
            $display("[TB] FAIL midrst_pipe got valid=%b dout=%0d required 0 0", out_valid, dout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_ghost got valid=%b required 0", out_valid);
        end
        applyStimulus(3'd5, 3'd0, 1'b0);
        getResult(d, oc);
        checks++;
        if (d !== 14'd0 || oc !== 3'd5) begin
            errors++;
            $display("[TB] FAIL midrst_ch5 got dout=%0d ch=%0d required dout=0 ch=5", d, oc);
        end
    endtask

`ifdef FILT_HOLD_EN
    // Held sample reports D and leaves the state alone
    task automatic test_hold();
        logic [13:0] d;
        logic [2:0]  oc;
        logic        hs [3];
        int          exps [3];
        hs   = '{1'b0, 1'b1, 1'b0};
        exps = '{112, 112, 223};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'd3, 3'd7, hs[i]);
            getResult(d, oc);
            checks++;
            if (d !== 14'(exps[i]) || oc !== 3'd3) begin
                errors++;
                $display("[TB] FAIL hold_%0d got dout=%0d ch=%0d required dout=%0d ch=3", i, d, oc, exps[i]);
            end
        end
    endtask
`endif

    // Runs every scenario in order and prints the summary
    initial begin
        checks = 0;
        errors = 0;
        $display("[TB] starting filt_lt_avg_mc bench");
        test_reset();
        test_basic();
        test_chain();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_reset_midway();
`ifdef FILT_HOLD_EN
        test_hold();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
